// File: rtl/ex_div_if.sv
// Operand/result handshake between the EX stage and the iterative divider.
// DIV_ZERO_FLAG_EN adds the div_zero_o status signal.
interface ex_div_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_zero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, div_zero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, div_zero_o
    );
`else
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
`endif
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Define DIV_ZERO_FLAG_EN to add the registered div_zero_o output.
module ex_div #(
    parameter int unsigned DATA_W = 32
) (
    input logic     clk,
    input logic     rst,
    ex_div_if.slave div_if
);
    localparam int unsigned           CntW    = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0]       CntLast = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                sgn_q;
    logic                dvd_neg_q;
    logic                dvs_neg_q;
    logic [2*DATA_W-1:0] res_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;
`ifdef DIV_ZERO_FLAG_EN
    logic                zero_path_q;
    logic                div_zero_q;
`endif

    logic [DATA_W:0]     trial;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   dvd_abs;
    logic [DATA_W-1:0]   dvs_abs;

    // quo_q starts as the dividend and shifts left; quotient bits fill in from the LSB.
    always_comb begin
        trial = {rem_q, quo_q[DATA_W-1]};
        diff  = trial - {1'b0, dvs_q};
        if (!diff[DATA_W]) begin
            rem_step = diff[DATA_W-1:0];
            quo_step = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_step = trial[DATA_W-1:0];
            quo_step = {quo_q[DATA_W-2:0], 1'b0};
        end
        quo_fix = (sgn_q && (dvd_neg_q != dvs_neg_q)) ? -quo_step : quo_step;
        rem_fix = (sgn_q && dvd_neg_q) ? -rem_step : rem_step;
        dvd_abs = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1]) ?
                  -div_if.opdata1_i : div_if.opdata1_i;
        dvs_abs = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1]) ?
                  -div_if.opdata2_i : div_if.opdata2_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFree;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            res_q       <= '0;
            result_q    <= '0;
            ready_q     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            zero_path_q <= 1'b0;
            div_zero_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StFree: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_q <= 1'b0;
`endif
                    if (div_if.start_i && !div_if.annul_i) begin
                        if (div_if.opdata2_i == '0) begin
                            state_q <= StByZero;
`ifdef DIV_ZERO_FLAG_EN
                            zero_path_q <= 1'b1;
`endif
                        end else begin
                            state_q   <= StOn;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= dvd_abs;
                            dvs_q     <= dvs_abs;
                            sgn_q     <= div_if.signed_div_i;
                            dvd_neg_q <= div_if.opdata1_i[DATA_W-1];
                            dvs_neg_q <= div_if.opdata2_i[DATA_W-1];
`ifdef DIV_ZERO_FLAG_EN
                            zero_path_q <= 1'b0;
`endif
                        end
                    end
                end
                StByZero: begin
                    res_q   <= '0;
                    state_q <= StEnd;
                end
                StOn: begin
                    if (div_if.annul_i) begin
                        state_q <= StFree;
                        cnt_q   <= '0;
                    end else begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + 1'b1;
                        // Last iteration folds the sign fix-up in directly.
                        if (cnt_q == CntLast) begin
                            res_q   <= {rem_fix, quo_fix};
                            state_q <= StEnd;
                        end
                    end
                end
                StEnd: begin
                    if (div_if.start_i) begin
                        ready_q  <= 1'b1;
                        result_q <= res_q;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= zero_path_q;
`endif
                    end else begin
                        state_q  <= StFree;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        result_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= StFree;
            endcase
        end
    end

    assign div_if.result_o = result_q;
    assign div_if.ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_if.div_zero_o = div_zero_q;
`endif
endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: expected results queued at issue, checked when ready_o rises.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] sb_q[$];

    ex_div_if #(.DATA_W(32)) dif ();

    ex_div #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called #1 after a rising edge with the DUT in FREE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int          edges;
        logic [63:0] want;
        logic [63:0] held;
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.annul_i      = 1'b0;
        dif.start_i      = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        // Operands must have been latched at accept.
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = ~sgn;
        check({tag, " ready_after_e0"}, {63'd0, dif.ready_o}, 64'd0);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (dif.ready_o) break;
        end
        check({tag, " latency"}, 64'(edges), 64'(lat));
        want = sb_q.pop_front();
        check({tag, " result"}, dif.result_o, want);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " div_zero"}, {63'd0, dif.div_zero_o}, {63'd0, (b == 32'd0)});
`endif
        held = dif.result_o;
        dif.annul_i = 1'b1;
        @(posedge clk); #1;
        dif.annul_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " end_hold"}, {dif.ready_o, dif.result_o[62:0]}, {1'b1, held[62:0]});
        dif.start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop_ready"}, {63'd0, dif.ready_o}, 64'd0);
        check({tag, " drop_result"}, dif.result_o, 64'd0);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        logic        rs;
        rst              = 1'b1;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {63'd0, dif.ready_o}, 64'd0);
        check("reset result", dif.result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset div_zero", {63'd0, dif.div_zero_o}, 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("div 7/-2", 1'b1, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 33);
        run_div("div 5/0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
        run_div("div 9/3", 1'b1, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 5) ? 32'($urandom_range(1, 15)) : $urandom;
            run_div("random", rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 2 : 33);
        end

        // Annul at E10 of a 100/7.
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk); #1;
        dif.annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (dif.ready_o) seen++;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div("div 8/2 after annul", 1'b0, 32'd8, 32'd2, 64'h00000000_00000004, 33);

        // Reset at E20 of a 100/7.
        dif.opdata1_i = 32'd100;
        dif.opdata2_i = 32'd7;
        dif.start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst ready", {63'd0, dif.ready_o}, 64'd0);
        check("midrst result", dif.result_o, 64'd0);
        dif.annul_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (dif.ready_o) seen++;
        end
        check("start+annul stays free", 64'(seen), 64'd0);
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        @(posedge clk); #1;
        run_div("divu 9/3 after rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
